// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one FIFO write port among NUM_CH channels using
// round-robin grants with bursts of up to BURST_LEN beats. The datapath is
// combinational; the arbitration state is registered.
// Optional build macro: FIFO_ARB_STATS_EN adds saturating per-channel stall counters.
module fifo_write_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arb_en,
  input  logic [NUM_CH-1:0]            prio_mask,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_en,
  output logic [CH_W-1:0]              wr_ch,
  input  logic                         wr_full,
  input  logic                         backpressure_active,
  output logic [CH_W-1:0]              owner,
  output logic                         busy,
  input  logic                         stat_clr,
  output logic [NUM_CH*16-1:0]         stall_cnt
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e          r_state;
  logic [CH_W-1:0] r_rr_ptr;
  logic [CH_W-1:0] r_owner;
  logic [7:0]      r_beat_cnt;
  logic            r_busy;

  logic [NUM_CH-1:0]     w_elig;
  logic [NUM_CH-1:0]     w_ready;
  logic                  w_found;
  logic [CH_W-1:0]       w_win;
  logic [CH_W-1:0]       w_sel;
  logic                  w_xfer;
  int unsigned           w_idx;
  logic [DATA_WIDTH-1:0] w_ch_word [NUM_CH];

  // Explicit compare so non-power-of-2 channel counts wrap correctly.
  function automatic logic [CH_W-1:0] f_next(input logic [CH_W-1:0] c);
    if (c == CH_W'(NUM_CH - 1)) return '0;
    return c + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_word
    assign w_ch_word[g] = ch_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Backpressure restricts eligibility to priority-masked channels.
  assign w_elig = ch_valid & ({NUM_CH{~backpressure_active}} | prio_mask);

  // First eligible channel scanning upward from the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_idx = 32'(r_rr_ptr) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_found && w_elig[CH_W'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = CH_W'(w_idx);
      end
    end
  end

  // Grant decode: new winner in idle, only the owner during a burst.
  always_comb begin
    w_ready = '0;
    w_sel   = '0;
    w_xfer  = 1'b0;
    if (!rst && arb_en && !wr_full) begin
      if (r_state == StIdle) begin
        if (w_found) begin
          w_xfer = 1'b1;
          w_sel  = w_win;
        end
      end else if (w_elig[r_owner]) begin
        w_xfer = 1'b1;
        w_sel  = r_owner;
      end
    end
    if (w_xfer) w_ready[w_sel] = 1'b1;
  end

  assign ch_ready = w_ready;
  assign wr_en    = w_xfer;
  assign wr_ch    = w_xfer ? w_sel : '0;
  assign wr_data  = w_xfer ? w_ch_word[w_sel] : '0;
  assign owner    = r_owner;
  assign busy     = r_busy;

  // Arbitration FSM: pointer, ownership and burst beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            if (BURST_LEN == 1) begin
              r_rr_ptr <= f_next(w_win);
            end else begin
              r_owner    <= w_win;
              r_beat_cnt <= 8'd1;
              r_state    <= StBurst;
              r_busy     <= 1'b1;
            end
          end
        end
        StBurst: begin
          if (!arb_en || !w_elig[r_owner]) begin
            // Release costs one bubble cycle.
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= f_next(r_owner);
          end else if (!wr_full) begin
            if ({1'b0, r_beat_cnt} + 9'd1 == 9'(BURST_LEN)) begin
              r_state    <= StIdle;
              r_busy     <= 1'b0;
              r_beat_cnt <= '0;
              r_rr_ptr   <= f_next(r_owner);
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stall [NUM_CH];

  // Saturating stall counters; clear wins over increment.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst || stat_clr) begin
        r_stall[i] <= '0;
      end else if (ch_valid[i] && !w_ready[i] && (r_stall[i] != 16'hFFFF)) begin
        r_stall[i] <= r_stall[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stall
    assign stall_cnt[g*16 +: 16] = r_stall[g];
  end
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stall_cnt         = '0;
`endif

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of hierarchical_fifo_system (wr_data/wr_en/wr_full) among NUM_CH acquisition channels.
- Round-robin arbitration with bounded bursts per grant.
- Honors FIFO full and backpressure_active: under backpressure, only priority-masked channels may write.
- Sits between the per-channel ADC front-ends and the FIFO; combinational datapath, registered arbitration state.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- DATA_WIDTH, 16, sample width; matches FIFO DATA_WIDTH
- BURST_LEN, 8, max consecutive beats per grant (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arb_en  in  1  arbitration enable
- prio_mask  in  NUM_CH  channels allowed to write while backpressure_active=1
- ch_valid  in  NUM_CH  per-channel sample valid
- ch_data  in  NUM_CH*DATA_WIDTH  per-channel sample; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_ready  out  NUM_CH  per-channel accept
- wr_data  out  DATA_WIDTH  to FIFO
- wr_en  out  1  to FIFO
- wr_ch  out  CH_W  source channel of the current beat; CH_W = max(1, $clog2(NUM_CH))
- wr_full  in  1  from FIFO
- backpressure_active  in  1  from FIFO
- owner  out  CH_W  channel currently holding the grant (valid when busy=1)
- busy  out  1  state==BURST
- stat_clr  in  1  clear statistics (STATS_EN only)
- stall_cnt  out  NUM_CH*16  per-channel stall counters (STATS_EN only)

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, busy=0. Outputs ch_ready, wr_en, wr_data and wr_ch are all 0 while rst=1.
- Eligibility: elig[i] = ch_valid[i] & (~backpressure_active | prio_mask[i]).
- Transfer: occurs on channel i in a cycle when ch_valid[i] & ch_ready[i].
  - In that cycle: wr_en=1, wr_data=ch_data[i], wr_ch=i.
  - Zero latency (combinational).
  - At most one ch_ready is high per cycle.
- ch_ready is never high while wr_full=1 or arb_en=0.
- IDLE state:
  - If arb_en & ~wr_full & |elig: the winner is the first eligible channel scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - ch_ready[winner]=1 and the beat transfers in this same cycle.
  - Next state:
    - BURST_LEN=1: stay IDLE, rr_ptr=winner+1 (mod NUM_CH).
    - Otherwise: owner=winner, beat_cnt=1, go to BURST.
  - Otherwise: stay IDLE, no ready.
- BURST state (owner o):
  - arb_en=0: ready=0, go to IDLE, rr_ptr=o+1.
  - elig[o]=0 (valid dropped, or backpressure on a non-priority channel): ready=0 (one bubble), go to IDLE, rr_ptr=o+1.
  - wr_full=1 with elig[o]=1: ready=0, hold BURST; beat_cnt and ownership unchanged.
  - Otherwise: ready[o]=1 and the beat transfers.
    - If beat_cnt+1 == BURST_LEN: go to IDLE, rr_ptr=o+1.
    - Else: beat_cnt increments, stay in BURST.
- No other channel can preempt the owner during BURST.
- rr_ptr wrap: NUM_CH-1 advances to 0. Non-power-of-2 NUM_CH uses explicit compare, not bit truncation.
- beat_cnt is 8 bits and never exceeds BURST_LEN-1.
- Reset mid-burst: the next cycle is IDLE with rr_ptr=0 and no transfer. Data in flight is the channel's responsibility, since ch_valid is held under the valid/ready rule.
- Channels must hold ch_valid and ch_data stable until accepted. The arbiter does not check this.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN
- Defined:
  - stall_cnt[i] increments (saturating at 16'hFFFF) each cycle where ch_valid[i]=1 & ch_ready[i]=0.
  - stat_clr=1 zeroes all counters; clear has priority over increment in the same cycle.
  - Reset value is 0.
- Undefined: stall_cnt is tied to 0 and stat_clr is ignored; no counter flops are generated. The port list is identical in both builds.

Test Plan:
- NUM_CH=4, BURST_LEN=8, all 4 channels valid continuously, channel i data = 16'h1000*i + seq.
  - Beats arrive as 8 from ch0, 8 ch1, 8 ch2, 8 ch3, then ch0 again.
  - wr_ch matches; per-channel sequence increments with no gaps.
- ch2 valid for only 3 beats, then drops, with ch3 valid.
  - ch2 transfers 3 beats, then 1 bubble cycle, then ch3 granted.
  - rr_ptr=3 after the release.
- wr_full asserted for 5 cycles mid-burst of ch1 (beat_cnt=4).
  - No wr_en and all ch_ready=0 for those 5 cycles.
  - ch1 resumes and completes exactly 4 more beats before rotation.
- backpressure_active=1, prio_mask=4'b0100, all valid.
  - Only ch2 is granted.
  - Releasing backpressure restores round-robin starting at ch3.
- rst pulsed during a ch1 burst.
  - Next cycle: busy=0, wr_en=0.
  - First grant after reset goes to ch0 when all channels are valid.
- FIFO_ARB_STATS_EN defined, ch3 valid but blocked 20 cycles → stall_cnt[3]=20.
  - stat_clr → 0.
  - Holding blocked for 70000 cycles saturates at 16'hFFFF.
